// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between an instruction-fetch
// requester (I port, read-only) and a load/store requester (D port). Each access runs
// IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP. Contested grants alternate round-robin.
//
// Ports:
//   clk, reset                  clock (rising edge) and asynchronous active-high reset
//   i_req/i_addr                fetch request, held until i_ack
//   i_ack/i_rvalid/i_rdata      accept pulse, data-valid pulse, fetched word
//   d_req/d_we/d_addr/d_wdata   load/store request, held until d_ack
//   d_ack/d_rvalid/d_rdata      accept pulse, load-valid/store-done pulse, load data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         memory access port
//   busy                        high whenever the FSM is not idle
// All outputs are registered.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_d_q, last_d_d;  // 1: last grant went to the D port
  logic            sel_d_q, sel_d_d;    // 1: access in flight belongs to the D port
  logic            we_q, we_d;          // access in flight is a store

  logic                  i_ack_d, d_ack_d, i_rvalid_d, d_rvalid_d;
  logic [DATA_WIDTH-1:0] i_rdata_d, d_rdata_d, mem_wdata_d;
  logic                  mem_en_d, mem_we_d, busy_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  logic take, grant_d, last_wait;

  // Requests are sampled in IDLE and in RESP; on a tie the port not granted last time wins.
  assign take      = ((state_q == StIdle) || (state_q == StResp)) && (i_req || d_req);
  assign grant_d   = d_req && (!i_req || !last_d_q);
  assign last_wait = (state_q == StWait) && (cnt_q == CntW'(1));

  // State register and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_d_q  <= 1'b1;
      sel_d_q   <= 1'b0;
      we_q      <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      sel_d_q   <= sel_d_d;
      we_q      <= we_d;
      i_ack     <= i_ack_d;
      d_ack     <= d_ack_d;
      i_rvalid  <= i_rvalid_d;
      d_rvalid  <= d_rvalid_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    last_d_d = last_d_q;
    sel_d_d  = sel_d_q;
    we_d     = we_q;
    if (take) begin
      last_d_d = grant_d;
      sel_d_d  = grant_d;
      we_d     = grant_d && d_we;
    end
    unique case (state_q)
      StIdle:  state_d = take ? StIssue : StIdle;
      StIssue: begin
        state_d = StWait;
        cnt_d   = CntW'(MEM_LATENCY);
      end
      StWait: begin
        cnt_d   = cnt_q - CntW'(1);
        state_d = last_wait ? StResp : StWait;
      end
      StResp:  state_d = take ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata;
    d_rdata_d   = d_rdata;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (take) begin
      // The mem_* registers double as the latch for the winner's request.
      i_ack_d     = !grant_d;
      d_ack_d     = grant_d;
      mem_en_d    = 1'b1;
      mem_we_d    = grant_d && d_we;
      mem_addr_d  = grant_d ? d_addr : i_addr;
      mem_wdata_d = grant_d ? d_wdata : '0;
    end
    if (last_wait) begin
      if (sel_d_q) begin
        d_rvalid_d = 1'b1;
        if (!we_q) d_rdata_d = mem_rdata;
      end else begin
        i_rvalid_d = 1'b1;
        i_rdata_d  = mem_rdata;
      end
    end
    busy_d = (state_d != StIdle);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses MEM_LATENCY=1, instance 1 MEM_LATENCY=3.
// Each instance has its own memory model and its own request inputs.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          i_req[2], i_ack[2], i_rvalid[2];
  logic          d_req[2], d_we[2], d_ack[2], d_rvalid[2];
  logic          mem_en[2], mem_we[2], busy[2];
  logic [AW-1:0] i_addr[2], d_addr[2], mem_addr[2];
  logic [DW-1:0] i_rdata[2], d_rdata[2], d_wdata[2], mem_wdata[2], mem_rdata[2];

  int checks = 0;
  int errors = 0;

  // Reference state: memory contents, last grant, expected rdata registers
  logic [DW-1:0] ref_mem[2][1 << AW];
  logic          last_d[2];
  logic [DW-1:0] exp_i_rdata[2], exp_d_rdata[2];

  function automatic logic [DW-1:0] mem_init(input int a);
    logic [DW-1:0] av;
    av = DW'(a);
    if (a == 4) return 32'h20080005;
    if (a == 32) return 32'h12345678;
    return av * 32'h9E3779B9 + 32'h1234;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int unsigned Lat = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem[1 << AW];
    logic [DW-1:0] pipe[Lat];

    initial for (int a = 0; a < (1 << AW); a++) mem[a] = mem_init(a);

    // Read data appears Lat cycles after the memory samples mem_en
    always @(posedge clk) begin
      if (mem_en[g]) begin
        if (mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
        pipe[0] <= mem[mem_addr[g]];
      end
      for (int k = 1; k < Lat; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = pipe[Lat-1];

    mem_port_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_LATENCY(Lat)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .i_req    (i_req[g]),
      .i_addr   (i_addr[g]),
      .i_ack    (i_ack[g]),
      .i_rvalid (i_rvalid[g]),
      .i_rdata  (i_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_ack    (d_ack[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g])
    );
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all_zero(input int g, input string name);
    chk(name, DW'({i_ack[g], i_rvalid[g], d_ack[g], d_rvalid[g], mem_en[g], mem_we[g], busy[g]}),
        '0);
    chk({name, "_addr"}, DW'(mem_addr[g]), '0);
    chk({name, "_wdata"}, mem_wdata[g], '0);
    chk({name, "_i_rdata"}, i_rdata[g], '0);
    chk({name, "_d_rdata"}, d_rdata[g], '0);
  endtask

  task automatic drive_idle(input int g);
    i_req[g] = 1'b0;
    d_req[g] = 1'b0;
    d_we[g]  = 1'b0;
  endtask

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      last_d[g]      = 1'b1;
      exp_i_rdata[g] = '0;
      exp_d_rdata[g] = '0;
    end
  endtask

  // One access: present requests, expect the given winner to be accepted in the next
  // cycle, then expect its rvalid exactly MEM_LATENCY+1 cycles after the ack cycle.
  task automatic run_txn(input int g, input logic ir, input logic dr, input logic we,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd, input logic win_d, input logic [DW-1:0] exp_rd);
    int   lat;
    logic st;
    lat = (g == 0) ? 1 : 3;
    st  = win_d && we;
    i_req[g] = ir;  i_addr[g] = ia;
    d_req[g] = dr;  d_we[g] = we;  d_addr[g] = da;  d_wdata[g] = wd;
    @(posedge clk); #1;
    chk("i_ack", DW'(i_ack[g]), DW'(!win_d));
    chk("d_ack", DW'(d_ack[g]), DW'(win_d));
    chk("mem_en_issue", DW'(mem_en[g]), 1);
    chk("mem_addr_issue", DW'(mem_addr[g]), DW'(win_d ? da : ia));
    chk("mem_we_issue", DW'(mem_we[g]), DW'(st));
    if (st) chk("mem_wdata_issue", mem_wdata[g], wd);
    chk("busy_issue", DW'(busy[g]), 1);
    if (win_d) d_req[g] = 1'b0;
    else i_req[g] = 1'b0;
    last_d[g] = win_d;
    if (st) ref_mem[g][da] = wd;
    else if (win_d) exp_d_rdata[g] = exp_rd;
    else exp_i_rdata[g] = exp_rd;
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk); #1;
      chk("ack_pulse", DW'({i_ack[g], d_ack[g]}), '0);
      chk("mem_idle", DW'({mem_en[g], mem_we[g], mem_addr[g]}), '0);
      chk("busy_wait", DW'(busy[g]), 1);
      if (c <= lat) begin
        chk("rvalid_early", DW'({i_rvalid[g], d_rvalid[g]}), '0);
      end else begin
        chk("i_rvalid", DW'(i_rvalid[g]), DW'(!win_d));
        chk("d_rvalid", DW'(d_rvalid[g]), DW'(win_d));
        chk("i_rdata", i_rdata[g], exp_i_rdata[g]);
        chk("d_rdata", d_rdata[g], exp_d_rdata[g]);
      end
    end
  endtask

  typedef struct {
    logic          ir, dr, we;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] wd;
    logic          win_d;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic          pi, pd, pwe, win;
    logic [AW-1:0] pia, pda;
    logic [DW-1:0] pwd;

    vt[0] = '{1, 1, 0, 10'h004, 10'h020, 32'h0, 0, 32'h20080005};  // first tie -> I
    vt[1] = '{0, 1, 0, 10'h004, 10'h020, 32'h0, 1, 32'h12345678};  // pending D load
    vt[2] = '{0, 1, 1, 10'h004, 10'h010, 32'hDEADBEEF, 1, 32'h0};  // store
    vt[3] = '{0, 1, 0, 10'h004, 10'h010, 32'h0, 1, 32'hDEADBEEF};  // load back
    vt[4] = '{1, 1, 0, 10'h004, 10'h010, 32'h0, 0, 32'h20080005};  // contention I,D,I,D
    vt[5] = '{1, 1, 0, 10'h004, 10'h010, 32'h0, 1, 32'hDEADBEEF};
    vt[6] = '{1, 1, 0, 10'h004, 10'h010, 32'h0, 0, 32'h20080005};
    vt[7] = '{1, 1, 0, 10'h004, 10'h010, 32'h0, 1, 32'hDEADBEEF};

    for (int g = 0; g < 2; g++) begin
      for (int a = 0; a < (1 << AW); a++) ref_mem[g][a] = mem_init(a);
      drive_idle(g);
      i_addr[g] = '0;  d_addr[g] = '0;  d_wdata[g] = '0;
    end
    model_reset();

    // Reset held, then released
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) chk_all_zero(g, "reset_held");
    #3 reset = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) chk_all_zero(g, "after_release");

    // Directed table on instance 0 (MEM_LATENCY = 1)
    for (int v = 0; v < 8; v++)
      run_txn(0, vt[v].ir, vt[v].dr, vt[v].we, vt[v].ia, vt[v].da, vt[v].wd, vt[v].win_d,
              vt[v].rd);
    drive_idle(0);

    // Latency 3: first tie goes to I, then a store/load pair
    run_txn(1, 1, 1, 0, 10'h004, 10'h020, 32'h0, 0, 32'h20080005);
    run_txn(1, 0, 1, 0, 10'h004, 10'h020, 32'h0, 1, 32'h12345678);
    run_txn(1, 0, 1, 1, 10'h004, 10'h033, 32'hCAFEF00D, 1, 32'h0);
    run_txn(1, 0, 1, 0, 10'h004, 10'h033, 32'h0, 1, 32'hCAFEF00D);
    drive_idle(1);

    // Random traffic against the reference model, both instances
    for (int g = 0; g < 2; g++) begin
      pi = 1'b0;  pd = 1'b0;
      pia = '0;  pda = '0;  pwe = 1'b0;  pwd = '0;
      repeat (60) begin
        if (!pi && ($urandom_range(1, 0) == 1)) begin
          pi  = 1'b1;
          pia = AW'($urandom_range(15, 0));
        end
        if (!pd && ($urandom_range(1, 0) == 1)) begin
          pd  = 1'b1;
          pda = AW'($urandom_range(15, 0));
          pwe = 1'($urandom_range(1, 0));
          pwd = $urandom;
        end
        if (!pi && !pd) begin
          drive_idle(g);
          @(posedge clk); #1;
          chk("busy_idle", DW'(busy[g]), 0);
          chk("rvalid_idle", DW'({i_rvalid[g], d_rvalid[g]}), '0);
        end else begin
          win = pd && (!pi || !last_d[g]);
          run_txn(g, pi, pd, pwe, pia, pda, pwd, win, win ? ref_mem[g][pda] : ref_mem[g][pia]);
          if (win) pd = 1'b0;
          else pi = 1'b0;
        end
      end
      drive_idle(g);
      @(posedge clk); #1;
    end

    // Reset during WAIT on instance 1: the in-flight load must vanish
    d_we[1] = 1'b0;  d_addr[1] = 10'h005;  d_req[1] = 1'b1;
    @(posedge clk); #1;
    chk("mid_ack", DW'(d_ack[1]), 1);
    d_req[1] = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", DW'(busy[1]), 1);
    #2 reset = 1'b1;
    #1;
    chk_all_zero(1, "mid_reset");
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("no_rvalid_after_reset", DW'({i_rvalid[1], d_rvalid[1], busy[1]}), '0);
    end
    run_txn(1, 1, 0, 0, 10'h004, 10'h000, 32'h0, 0, 32'h20080005);
    run_txn(1, 1, 1, 0, 10'h004, 10'h020, 32'h0, 1, 32'h12345678);
    drive_idle(1);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
